// File: rtl/line_buffer.sv
// Raster-order line buffer: keeps the two previous image lines and emits a
// vertical 3-pixel column per accepted pixel, zero-padded at the top of the frame.
module line_buffer #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int DATA_W     = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] pix_in,
   input  logic              pix_valid_in,
   input  logic              sof,
   output logic [DATA_W-1:0] row0_out,
   output logic [DATA_W-1:0] row1_out,
   output logic [DATA_W-1:0] row2_out,
   output logic              pixel_valid,
   output logic [10:0]       x,
   output logic [9:0]        y,
   output logic              rows_ok,
   output logic              frame_done
);

   localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

   logic [DATA_W-1:0] line_prev  [IMG_WIDTH];
   logic [DATA_W-1:0] line_prev2 [IMG_WIDTH];

   logic [10:0]   cx;
   logic [10:0]   cx_eff;
   logic [10:0]   cx_next;
   logic [9:0]    cy;
   logic [9:0]    cy_eff;
   logic [9:0]    cy_next;
   logic          last_col;
   logic          last_row;
   logic [AW-1:0] idx;
   state_t        state;

   // sof forces the current pixel to (0,0); derive the position used this cycle and the next one
   always_comb begin
      cx_eff   = sof ? 11'd0 : cx;
      cy_eff   = sof ? 10'd0 : cy;
      last_col = (cx_eff == 11'(IMG_WIDTH - 1));
      last_row = (cy_eff == 10'(IMG_HEIGHT - 1));
      idx      = cx_eff[AW-1:0];
      if (last_col) begin
         cx_next = 11'd0;
         cy_next = last_row ? 10'd0 : cy_eff + 10'd1;
      end else begin
         cx_next = cx_eff + 11'd1;
         cy_next = cy_eff;
      end
   end

   // Column-wise shift of the two stored lines; left unreset so it can map to RAM
   always_ff @(posedge clk) begin
      if (pix_valid_in) begin
         line_prev2[idx] <= line_prev[idx];
         line_prev[idx]  <= pix_in;
      end
   end

   // Counters, padded column output and the informational frame state
   always_ff @(posedge clk) begin
      if (reset) begin
         row0_out    <= '0;
         row1_out    <= '0;
         row2_out    <= '0;
         pixel_valid <= 1'b0;
         x           <= 11'd0;
         y           <= 10'd0;
         rows_ok     <= 1'b0;
         frame_done  <= 1'b0;
         cx          <= 11'd0;
         cy          <= 10'd0;
         state       <= IDLE;
      end else begin
         pixel_valid <= pix_valid_in;
         frame_done  <= pix_valid_in & last_col & last_row;
         if (pix_valid_in) begin
            // Stored lines may hold reset or previous-frame data; mask by line number
            row2_out <= pix_in;
            row1_out <= (cy_eff >= 10'd1) ? line_prev[idx]  : '0;
            row0_out <= (cy_eff >= 10'd2) ? line_prev2[idx] : '0;
            x        <= cx_eff;
            y        <= cy_eff;
            rows_ok  <= (cy_eff >= 10'd2);
            cx       <= cx_next;
            cy       <= cy_next;
         end else if (sof) begin
            cx <= 11'd0;
            cy <= 10'd0;
         end
         case (state)
            IDLE: begin
               if (pix_valid_in) begin
                  state <= (cy_next >= 10'd2) ? STREAM : FILL;
               end
            end
            FILL, STREAM: begin
               if (pix_valid_in) begin
                  state <= (cy_next >= 10'd2) ? STREAM : FILL;
               end else if (sof) begin
                  state <= FILL;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_line_buffer.sv
// Scoreboard bench for line_buffer: a 4x4 instance for directed scenarios and
// a 640-wide instance (3 lines) for a random-pixel smoke run.
module tb_line_buffer;

   typedef struct packed {
      logic [7:0]  r0;
      logic [7:0]  r1;
      logic [7:0]  r2;
      logic [10:0] x;
      logic [9:0]  y;
      logic        ok;
      logic        fd;
   } out_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // instance 0: 4x4
   logic       rst_s = 1'b0, v_s = 1'b0, sof_s = 1'b0;
   logic [7:0] pix_s = 8'd0;
   logic [7:0] r0_s, r1_s, r2_s;
   logic       pv_s, ok_s, fd_s;
   logic [10:0] x_s;
   logic [9:0]  y_s;
   // instance 1: 640x3
   logic       rst_b = 1'b0, v_b = 1'b0, sof_b = 1'b0;
   logic [7:0] pix_b = 8'd0;
   logic [7:0] r0_b, r1_b, r2_b;
   logic       pv_b, ok_b, fd_b;
   logic [10:0] x_b;
   logic [9:0]  y_b;

   line_buffer #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .DATA_W(8)) dut_s (
      .clk(clk), .reset(rst_s), .pix_in(pix_s), .pix_valid_in(v_s), .sof(sof_s),
      .row0_out(r0_s), .row1_out(r1_s), .row2_out(r2_s), .pixel_valid(pv_s),
      .x(x_s), .y(y_s), .rows_ok(ok_s), .frame_done(fd_s));

   line_buffer #(.IMG_WIDTH(640), .IMG_HEIGHT(3), .DATA_W(8)) dut_b (
      .clk(clk), .reset(rst_b), .pix_in(pix_b), .pix_valid_in(v_b), .sof(sof_b),
      .row0_out(r0_b), .row1_out(r1_b), .row2_out(r2_b), .pixel_valid(pv_b),
      .x(x_b), .y(y_b), .rows_ok(ok_b), .frame_done(fd_b));

   int errors = 0;
   int checks = 0;

   out_t q0[$];
   out_t q1[$];
   out_t held [2];
   logic en [2] = '{1'b0, 1'b0};
   int   fd_cnt [2] = '{0, 0};
   int   max_x [2] = '{0, 0};
   int   max_y [2] = '{0, 0};

   // reference image: pixels of the current frame, indexed [inst][line][column]
   logic [7:0] img [0:1][0:3][0:639];
   int mcx [2] = '{0, 0};
   int mcy [2] = '{0, 0};
   int W [2] = '{4, 640};
   int H [2] = '{4, 3};

   task automatic chk(input string n, input int i, input out_t got, input out_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s inst%0d: got r0=%h r1=%h r2=%h x=%0d y=%0d ok=%b fd=%b, want r0=%h r1=%h r2=%h x=%0d y=%0d ok=%b fd=%b",
                  n, i, got.r0, got.r1, got.r2, got.x, got.y, got.ok, got.fd,
                  exp.r0, exp.r1, exp.r2, exp.x, exp.y, exp.ok, exp.fd);
      end
   endtask

   task automatic chk_int(input string n, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", n, got, exp);
      end
   endtask

   task automatic mon(input int i, input out_t got, input logic v);
      out_t e;
      out_t h;
      if (en[i]) begin
         if (v === 1'b1) begin
            if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
               checks++;
               errors++;
               $display("FAIL unexpected_valid inst%0d: got pixel_valid=1, want 0 (nothing pending)", i);
            end else begin
               e = (i == 0) ? q0.pop_front() : q1.pop_front();
               chk("column", i, got, e);
               h = e;
               h.fd = 1'b0;
               held[i] = h;
               if (got.fd === 1'b1) fd_cnt[i]++;
               if (int'(got.x) > max_x[i]) max_x[i] = int'(got.x);
               if (int'(got.y) > max_y[i]) max_y[i] = int'(got.y);
               if (i == 0 && got.x == 11'd2 && got.y == 10'd2)
                  chk("spot_2_2", i, got, {8'h02, 8'h12, 8'h22, 11'd2, 10'd2, 1'b1, 1'b0});
               if (i == 0 && got.x == 11'd3 && got.y == 10'd1)
                  chk("spot_3_1", i, got, {8'h00, 8'h03, 8'h13, 11'd3, 10'd1, 1'b0, 1'b0});
            end
         end else begin
            chk("hold", i, got, held[i]);
         end
      end
   endtask

   always @(negedge clk) mon(0, {r0_s, r1_s, r2_s, x_s, y_s, ok_s, fd_s}, pv_s);
   always @(negedge clk) mon(1, {r0_b, r1_b, r2_b, x_b, y_b, ok_b, fd_b}, pv_b);

   task automatic drive(input int i, input logic v, input logic s, input logic [7:0] p, input logic r);
      out_t e;
      if (i == 0) begin
         v_s = v; sof_s = s; pix_s = p; rst_s = r;
      end else begin
         v_b = v; sof_b = s; pix_b = p; rst_b = r;
      end
      if (r) begin
         mcx[i] = 0;
         mcy[i] = 0;
      end else begin
         if (s) begin
            mcx[i] = 0;
            mcy[i] = 0;
         end
         if (v) begin
            e.x  = 11'(mcx[i]);
            e.y  = 10'(mcy[i]);
            e.r2 = p;
            e.r1 = (mcy[i] >= 1) ? img[i][mcy[i]-1][mcx[i]] : 8'h00;
            e.r0 = (mcy[i] >= 2) ? img[i][mcy[i]-2][mcx[i]] : 8'h00;
            e.ok = (mcy[i] >= 2);
            e.fd = (mcx[i] == W[i] - 1) && (mcy[i] == H[i] - 1);
            img[i][mcy[i]][mcx[i]] = p;
            if (i == 0) q0.push_back(e); else q1.push_back(e);
            if (mcx[i] == W[i] - 1) begin
               mcx[i] = 0;
               mcy[i] = (mcy[i] == H[i] - 1) ? 0 : mcy[i] + 1;
            end else begin
               mcx[i] = mcx[i] + 1;
            end
         end
      end
      @(posedge clk);
      #1;
      if (r) begin
         held[i] = '0;
         en[i] = 1'b1;
         if (i == 0) begin
            chk("reset_outputs", i, {r0_s, r1_s, r2_s, x_s, y_s, ok_s, fd_s}, '0);
            chk_int("reset_pixel_valid", int'(pv_s), 0);
         end else begin
            chk("reset_outputs", i, {r0_b, r1_b, r2_b, x_b, y_b, ok_b, fd_b}, '0);
            chk_int("reset_pixel_valid", int'(pv_b), 0);
         end
         if (i == 0) rst_s = 1'b0; else rst_b = 1'b0;
      end
   endtask

   task automatic raster_px(input int k);
      drive(0, 1'b1, 1'b0, 8'((k / 4) * 16 + (k % 4)), 1'b0);
   endtask

   initial begin
      drive(0, 1'b0, 1'b0, 8'h00, 1'b1);
      drive(1, 1'b0, 1'b0, 8'h00, 1'b1);

      // two continuous frames, wrapping without sof
      for (int f = 0; f < 2; f++)
         for (int k = 0; k < 16; k++) raster_px(k);
      // third frame with valid pattern 1,0,0
      for (int k = 0; k < 16; k++) begin
         raster_px(k);
         drive(0, 1'b0, 1'b0, 8'h5A, 1'b0);
         drive(0, 1'b0, 1'b0, 8'hA5, 1'b0);
      end
      // abort after (1,2) with sof carrying 0xAA
      for (int k = 0; k < 10; k++) raster_px(k);
      drive(0, 1'b1, 1'b1, 8'hAA, 1'b0);
      for (int k = 1; k < 10; k++) raster_px(k);
      // sof without a pixel, then reset while pixel (2,3) is offered
      drive(0, 1'b0, 1'b1, 8'h00, 1'b0);
      for (int k = 0; k < 14; k++) raster_px(k);
      drive(0, 1'b1, 1'b0, 8'h32, 1'b1);
      for (int k = 0; k < 5; k++) raster_px(k);
      drive(0, 1'b0, 1'b0, 8'h00, 1'b0);
      drive(0, 1'b0, 1'b0, 8'h00, 1'b0);

      // wide instance: two frames of random pixels with sparse gaps
      for (int f = 0; f < 2; f++)
         for (int yy = 0; yy < 3; yy++)
            for (int xx = 0; xx < 640; xx++) begin
               drive(1, 1'b1, 1'b0, 8'($urandom_range(0, 255)), 1'b0);
               if ((xx % 97) == 5) drive(1, 1'b0, 1'b0, 8'h00, 1'b0);
            end
      drive(1, 1'b0, 1'b0, 8'h00, 1'b0);
      drive(1, 1'b0, 1'b0, 8'h00, 1'b0);

      chk_int("pending_inst0", q0.size(), 0);
      chk_int("pending_inst1", q1.size(), 0);
      chk_int("frame_done_count_inst0", fd_cnt[0], 3);
      chk_int("frame_done_count_inst1", fd_cnt[1], 2);
      chk_int("max_x_inst1", max_x[1], 639);
      chk_int("max_y_inst1", max_y[1], 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
